// File: rtl/fetch_pkg.sv
// Shared types and helpers for the IF-stage fetch controller.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        FIM    = 2'd2
    } estado_t;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // One fetch buffer slot: instruction word plus the PC it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entrada_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] alinha_palavra(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

    // True when a byte address does not sit on a word boundary.
    function automatic logic desalinhado(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch FIFO. Slots are zeroed when vacated so the head register
// can drive decode directly and reads as zero whenever the buffer is empty.
// Flush beats push; push and pop may coincide.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entrada_t   din,
    output entrada_t   head,
    output logic       valid,
    output logic [1:0] count
);

    entrada_t   head_r;
    entrada_t   tail_r;
    logic [1:0] count_r;
    entrada_t   head_s;
    entrada_t   tail_s;
    logic [1:0] count_s;
    logic       pop_ok_s;

    // Next-state computation for both slots and the occupancy count.
    always_comb begin
        head_s   = head_r;
        tail_s   = tail_r;
        count_s  = count_r;
        pop_ok_s = pop && (count_r != 2'd0);
        if (flush) begin
            head_s  = '0;
            tail_s  = '0;
            count_s = 2'd0;
        end else begin
            case ({push, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_s  = din;
                        count_s = 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_s  = din;
                        count_s = 2'd2;
                    end else begin
                        // Push into a full buffer is never requested; hold.
                        count_s = count_r;
                    end
                end
                2'b01: begin
                    // Tail slot is already zero when only one entry is held.
                    head_s  = tail_r;
                    tail_s  = '0;
                    count_s = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_s = din;
                    end else begin
                        head_s = tail_r;
                        tail_s = din;
                    end
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end
    end

    // Slot and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            count_r <= count_s;
        end
    end

    assign head  = head_r;
    assign valid = (count_r != 2'd0);
    assign count = count_r;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch controller: owns the PC, reads the combinational
// instruction memory, buffers fetched words for decode, and handles
// redirects and end-of-program detection.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          NUM_INSTR = 13,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] endereco,
    input  logic [31:0] instrucao,
    input  logic        desvio_valido,
    input  logic [31:0] desvio_alvo,
    output logic        if_valido,
    input  logic        if_pronto,
    output logic [31:0] if_instrucao,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_mais4,
    output logic        fim_programa,
    output logic        erro_alinhamento,
    output logic [31:0] contador_busca
);

    localparam logic [29:0] NUM_WORDS = NUM_INSTR[29:0];
    localparam logic [1:0]  DEPTH     = BUF_DEPTH[1:0];

    estado_t     estado_r;
    estado_t     estado_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] contador_r;
    logic [31:0] contador_s;
    logic        fim_r;
    logic        fim_s;
    logic        erro_r;
    logic        erro_s;

    logic        push_s;
    logic        flush_s;
    logic        pop_s;
    logic        em_faixa_s;
    logic        alvo_em_faixa_s;
    logic [1:0]  cnt_prox_s;
    entrada_t    entrada_s;
    entrada_t    head_s;
    logic        valid_s;
    logic [1:0]  buf_count_s;

    fetch_buffer u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   (entrada_s),
        .head  (head_s),
        .valid (valid_s),
        .count (buf_count_s)
    );

    // Sequencer next state, PC update, buffer control and output precompute.
    always_comb begin
        estado_s        = estado_r;
        pc_s            = pc_r;
        contador_s      = contador_r;
        push_s          = 1'b0;
        flush_s         = 1'b0;
        pop_s           = valid_s && if_pronto;
        em_faixa_s      = (pc_r[31:2] < NUM_WORDS);
        alvo_em_faixa_s = (desvio_alvo[31:2] < NUM_WORDS);
        entrada_s       = '{instr: instrucao, pc: pc_r};
        case (estado_r)
            INICIO: begin
                // No fetch here; an early redirect still lands in the PC.
                estado_s = BUSCA;
                if (desvio_valido) begin
                    flush_s = 1'b1;
                    pc_s    = alinha_palavra(desvio_alvo);
                end else begin
                    pc_s = pc_r;
                end
            end
            BUSCA: begin
                if (desvio_valido) begin
                    // Out-of-range targets are caught by the range check next cycle.
                    flush_s = 1'b1;
                    pc_s    = alinha_palavra(desvio_alvo);
                end else if (!em_faixa_s) begin
                    estado_s = FIM;
                end else if ((buf_count_s < DEPTH) || pop_s) begin
                    push_s     = 1'b1;
                    pc_s       = pc_r + WORD_BYTES;
                    contador_s = contador_r + 32'd1;
                end else begin
                    pc_s = pc_r;
                end
            end
            FIM: begin
                if (desvio_valido) begin
                    flush_s  = 1'b1;
                    pc_s     = alinha_palavra(desvio_alvo);
                    estado_s = alvo_em_faixa_s ? BUSCA : FIM;
                end else begin
                    estado_s = FIM;
                end
            end
            default: begin
                estado_s = INICIO;
                pc_s     = RESET_PC;
                flush_s  = 1'b1;
            end
        endcase

        if (flush_s) begin
            cnt_prox_s = 2'd0;
        end else begin
            cnt_prox_s = buf_count_s + {1'b0, push_s} - {1'b0, pop_s};
        end
        // Registered so the flag lines up with the state it describes.
        fim_s  = (estado_s == FIM) && (cnt_prox_s == 2'd0);
        erro_s = desvio_valido && desalinhado(desvio_alvo);
    end

    // State, PC, fetch counter and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r   <= INICIO;
            pc_r       <= RESET_PC;
            contador_r <= 32'd0;
            fim_r      <= 1'b0;
            erro_r     <= 1'b0;
        end else begin
            estado_r   <= estado_s;
            pc_r       <= pc_s;
            contador_r <= contador_s;
            fim_r      <= fim_s;
            erro_r     <= erro_s;
        end
    end

    assign endereco         = pc_r;
    assign if_valido        = valid_s;
    assign if_instrucao     = head_s.instr;
    assign if_pc            = head_s.pc;
    // Follows the head PC, so it reads 4 while the buffer is empty.
    assign if_pc_mais4      = head_s.pc + WORD_BYTES;
    assign fim_programa     = fim_r;
    assign erro_alinhamento = erro_r;
    assign contador_busca   = contador_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a PC scoreboard checked on every pop.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    logic        desvio_valido;
    logic [31:0] desvio_alvo;
    logic        if_valido;
    logic        if_pronto;
    logic [31:0] if_instrucao;
    logic [31:0] if_pc;
    logic [31:0] if_pc_mais4;
    logic        fim_programa;
    logic        erro_alinhamento;
    logic [31:0] contador_busca;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_pc[$];

    fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .NUM_INSTR (13),
        .BUF_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .endereco         (endereco),
        .instrucao        (instrucao),
        .desvio_valido    (desvio_valido),
        .desvio_alvo      (desvio_alvo),
        .if_valido        (if_valido),
        .if_pronto        (if_pronto),
        .if_instrucao     (if_instrucao),
        .if_pc            (if_pc),
        .if_pc_mais4      (if_pc_mais4),
        .fim_programa     (fim_programa),
        .erro_alinhamento (erro_alinhamento),
        .contador_busca   (contador_busca)
    );

    always #5 clk = ~clk;

    // Program memory: words 0..12 hold 0x11+i, anything beyond is a marker.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [29:0] idx;
        idx = addr[31:2];
        if (idx < 30'd13) return 32'h11 + {2'b00, idx};
        else return 32'hBAD0_0000 | {2'b00, idx};
    endfunction

    assign instrucao = mem_word(endereco);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // On every handshake, compare the head against the oldest expected PC.
    task automatic sb_check();
        logic [31:0] e;
        if (if_valido === 1'b1 && if_pronto === 1'b1) begin
            chk("sb_nonempty", (sb_pc.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_pc.size() > 0) begin
                e = sb_pc.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instrucao, mem_word(e));
                chk("sb_pc4", if_pc_mais4, e + 32'd4);
            end
        end
    endtask

    // One cycle: drive inputs at the falling edge, then sample mid-cycle.
    task automatic drive(input logic pr, input logic dv, input logic [31:0] alvo);
        @(negedge clk);
        if_pronto     = pr;
        desvio_valido = dv;
        desvio_alvo   = alvo;
        #1;
        sb_check();
    endtask

    // Release reset; returns sampling inside cycle 0 (the INICIO cycle).
    task automatic release_reset(input logic pr);
        @(negedge clk);
        rst_n         = 1'b1;
        if_pronto     = pr;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'd0;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_pc.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        if_pronto     = 1'b0;
        desvio_valido = 1'b0;
        desvio_alvo   = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_endereco", endereco, 32'h0);
        chk("rst_valido", {31'd0, if_valido}, 32'd0);
        chk("rst_instr", if_instrucao, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_mais4, 32'h4);
        chk("rst_fim", {31'd0, fim_programa}, 32'd0);
        chk("rst_erro", {31'd0, erro_alinhamento}, 32'd0);
        chk("rst_contador", contador_busca, 32'd0);

        // Straight-line run of the whole program with decode always ready.
        for (int i = 0; i < 13; i++) sb_pc.push_back(32'(4 * i));
        release_reset(1'b1);
        chk("s1_c0_valido", {31'd0, if_valido}, 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        chk("s1_c1_valido", {31'd0, if_valido}, 32'd0);
        chk("s1_c1_endereco", endereco, 32'h0);
        for (int k = 2; k <= 14; k++) begin
            drive(1'b1, 1'b0, 32'd0);
            chk("s1_valido", {31'd0, if_valido}, 32'd1);
            chk("s1_pc", if_pc, 32'(4 * (k - 2)));
            chk("s1_fim_low", {31'd0, fim_programa}, 32'd0);
        end
        drive(1'b1, 1'b0, 32'd0);
        chk("s1_fim", {31'd0, fim_programa}, 32'd1);
        chk("s1_contador", contador_busca, 32'd13);
        chk("s1_valido_end", {31'd0, if_valido}, 32'd0);
        chk("s1_sb_empty", 32'(sb_pc.size()), 32'd0);

        // Back-pressure: buffer fills with 0 and 4, PC parks at 8.
        pulse_reset();
        sb_pc.push_back(32'h0);
        sb_pc.push_back(32'h4);
        sb_pc.push_back(32'h8);
        release_reset(1'b0);
        for (int c = 1; c <= 3; c++) drive(1'b0, 1'b0, 32'd0);
        chk("s2_full_valido", {31'd0, if_valido}, 32'd1);
        chk("s2_full_head", if_pc, 32'h0);
        chk("s2_full_endereco", endereco, 32'h8);
        chk("s2_full_contador", contador_busca, 32'd2);
        for (int c = 4; c <= 6; c++) drive(1'b0, 1'b0, 32'd0);
        chk("s2_hold_endereco", endereco, 32'h8);
        chk("s2_hold_head", if_pc, 32'h0);
        chk("s2_hold_contador", contador_busca, 32'd2);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 7: pop 0, fetch 8

        // Redirect to 0x20 while PCs 4 and 8 are buffered.
        drive(1'b0, 1'b1, 32'h20);                     // cycle 8
        chk("s3_pre_head", if_pc, 32'h4);
        sb_pc.delete();
        sb_pc.push_back(32'h20);
        sb_pc.push_back(32'h24);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 9
        chk("s3_flushed", {31'd0, if_valido}, 32'd0);
        chk("s3_endereco", endereco, 32'h20);
        chk("s3_erro", {31'd0, erro_alinhamento}, 32'd0);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 10
        chk("s3_valido", {31'd0, if_valido}, 32'd1);
        chk("s3_pc", if_pc, 32'h20);
        chk("s3_pc4", if_pc_mais4, 32'h24);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 11

        // Misaligned redirect target 0x22.
        drive(1'b0, 1'b1, 32'h22);                     // cycle 12
        chk("s4_erro_pre", {31'd0, erro_alinhamento}, 32'd0);
        sb_pc.delete();
        sb_pc.push_back(32'h20);
        sb_pc.push_back(32'h24);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 13
        chk("s4_erro", {31'd0, erro_alinhamento}, 32'd1);
        chk("s4_endereco", endereco, 32'h20);
        chk("s4_valido", {31'd0, if_valido}, 32'd0);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 14
        chk("s4_erro_post", {31'd0, erro_alinhamento}, 32'd0);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 15

        // Redirect past the end of the program, then back to 0x08.
        drive(1'b0, 1'b1, 32'h40);                     // cycle 16
        sb_pc.delete();
        drive(1'b1, 1'b0, 32'd0);                      // cycle 17
        chk("s5_endereco", endereco, 32'h40);
        chk("s5_valido", {31'd0, if_valido}, 32'd0);
        chk("s5_fim_low", {31'd0, fim_programa}, 32'd0);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 18
        chk("s5_fim", {31'd0, fim_programa}, 32'd1);
        chk("s5_contador", contador_busca, 32'd9);
        chk("s5_endereco_hold", endereco, 32'h40);
        drive(1'b1, 1'b1, 32'h08);                     // cycle 19
        chk("s5_fim_still", {31'd0, fim_programa}, 32'd1);
        sb_pc.push_back(32'h8);
        sb_pc.push_back(32'hC);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 20
        chk("s5_resume_fim", {31'd0, fim_programa}, 32'd0);
        chk("s5_resume_endereco", endereco, 32'h8);
        chk("s5_resume_valido", {31'd0, if_valido}, 32'd0);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 21
        chk("s5_resume_pc", if_pc, 32'h8);
        drive(1'b1, 1'b0, 32'd0);                      // cycle 22

        // Fill the buffer, then reset in the middle of the stream.
        drive(1'b0, 1'b0, 32'd0);                      // cycle 23
        drive(1'b0, 1'b0, 32'd0);                      // cycle 24
        chk("s6_full_valido", {31'd0, if_valido}, 32'd1);
        chk("s6_full_head", if_pc, 32'h10);
        chk("s6_full_endereco", endereco, 32'h18);
        chk("s6_contador", contador_busca, 32'd13);
        pulse_reset();
        chk("s6_rst_valido", {31'd0, if_valido}, 32'd0);
        chk("s6_rst_contador", contador_busca, 32'd0);
        chk("s6_rst_endereco", endereco, 32'h0);
        chk("s6_rst_pc", if_pc, 32'h0);
        chk("s6_rst_fim", {31'd0, fim_programa}, 32'd0);
        sb_pc.push_back(32'h0);
        release_reset(1'b1);
        drive(1'b1, 1'b0, 32'd0);
        chk("s6_restart_endereco", endereco, 32'h0);
        drive(1'b1, 1'b0, 32'd0);
        chk("s6_restart_valido", {31'd0, if_valido}, 32'd1);
        chk("s6_restart_pc", if_pc, 32'h0);
        chk("s6_sb_empty", 32'(sb_pc.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
